// File: rtl/usb_hs_tx_serializer.sv
// USB2 high-speed transmit bit engine: SYNC, LSB-first payload with bit stuffing,
// NRZI line coding and EOP, fed by a one-byte holding register over valid/ready.
module usb_hs_tx_serializer #(
    parameter int SYNC_BITS = 32,
    parameter int EOP_BITS  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    input  logic       data_last,
    output logic       data_ready,
    output logic       tx_en,
    output logic       tx_line,
    output logic       underrun
);

    localparam int MAX_BITS = (SYNC_BITS > EOP_BITS) ? SYNC_BITS : EOP_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_BITS - 1);
    localparam logic [CNT_W-1:0] EOP_LAST  = CNT_W'(EOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_STUFF,
        S_EOP
    } state_t;

    // The state names the kind of bit currently on the line.
    state_t           r_state;
    state_t           w_next_state;

    logic [7:0]       r_hold;
    logic             r_hold_full;
    logic             r_hold_last;
    logic             r_last_seen;
    logic [7:0]       r_shift;
    logic             r_cur_last;
    logic [2:0]       r_bit_cnt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_ones;
    logic             r_line;
    logic             r_underrun;

    logic             w_ready;
    logic             w_accept;
    logic             w_sync_end;
    logic             w_eop_end;
    logic             w_stuff;
    logic             w_step;
    logic             w_byte_end;
    logic             w_load;
    logic             w_abort;
    logic             w_finish;
    logic             w_raw;
    logic             w_line_next;
    logic [2:0]       w_ones_next;

    assign w_ready    = !r_hold_full && !r_last_seen &&
                        (r_state == S_IDLE || r_state == S_SYNC || r_state == S_DATA);
    assign w_accept   = data_valid && w_ready;
    assign w_sync_end = (r_state == S_SYNC) && (r_cnt == SYNC_LAST);
    assign w_eop_end  = (r_state == S_EOP) && (r_cnt == EOP_LAST);
    assign w_stuff    = (r_state == S_DATA) && (r_ones == 3'd6);
    assign w_step     = ((r_state == S_DATA) && !w_stuff) || (r_state == S_STUFF);
    assign w_byte_end = w_step && (r_bit_cnt == 3'd7);
    assign w_finish   = w_byte_end && r_cur_last;
    assign w_abort    = w_byte_end && !r_cur_last && !r_hold_full;
    assign w_load     = w_sync_end || (w_byte_end && !r_cur_last && r_hold_full);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_SYNC;
            S_SYNC:  if (w_sync_end) w_next_state = S_DATA;
            S_DATA: begin
                if (w_stuff)                   w_next_state = S_STUFF;
                else if (w_finish || w_abort)  w_next_state = S_EOP;
            end
            S_STUFF: w_next_state = (w_finish || w_abort) ? S_EOP : S_DATA;
            S_EOP:   if (w_eop_end) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Raw bit for the next bit time, then its NRZI level and the updated ones run.
    always_comb begin
        w_raw = 1'b1;
        case (r_state)
            S_IDLE: w_raw = (SYNC_LAST == '0);
            S_SYNC: w_raw = w_sync_end ? r_hold[0] : ((r_cnt + CNT_W'(1)) == SYNC_LAST);
            S_DATA, S_STUFF: begin
                if (w_stuff)          w_raw = 1'b0;
                else if (w_load)      w_raw = r_hold[0];
                else if (!w_byte_end) w_raw = r_shift[1];
                else                  w_raw = 1'b1;
            end
            default: w_raw = 1'b1;
        endcase

        w_line_next = (w_next_state == S_IDLE) ? 1'b1 : (w_raw ? r_line : ~r_line);

        w_ones_next = 3'd0;
        if (w_next_state == S_SYNC || w_next_state == S_DATA || w_next_state == S_STUFF) begin
            if (w_raw) w_ones_next = (r_ones == 3'd7) ? 3'd7 : r_ones + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (w_accept) r_hold <= data_in;
        if (w_load)       r_shift <= r_hold;
        else if (w_step)  r_shift <= {1'b0, r_shift[7:1]};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_hold_full <= 1'b0;
            r_hold_last <= 1'b0;
            r_last_seen <= 1'b0;
            r_cur_last  <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_cnt       <= '0;
            r_ones      <= 3'd0;
            r_line      <= 1'b1;
            r_underrun  <= 1'b0;
        end else begin
            // Accept and load on one edge: old byte moves on, new byte stays held.
            if (w_eop_end) begin
                r_hold_full <= 1'b0;
                r_last_seen <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_hold_full <= 1'b1;
                    r_hold_last <= data_last;
                    if (data_last) r_last_seen <= 1'b1;
                end else if (w_load) begin
                    r_hold_full <= 1'b0;
                end
            end

            if (w_load) begin
                r_cur_last <= r_hold_last;
                r_bit_cnt  <= 3'd0;
            end else if (w_step) begin
                r_bit_cnt  <= r_bit_cnt + 3'd1;
            end

            if (w_next_state != r_state)                 r_cnt <= '0;
            else if (r_state == S_SYNC || r_state == S_EOP) r_cnt <= r_cnt + CNT_W'(1);

            r_ones     <= w_ones_next;
            r_line     <= w_line_next;
            r_underrun <= w_abort;
        end
    end

    assign data_ready = w_ready;
    assign tx_en      = (r_state != S_IDLE);
    assign tx_line    = r_line;
    assign underrun   = r_underrun;

endmodule

// File: tb/tb_usb_hs_tx_serializer.sv
// Directed bench for usb_hs_tx_serializer with SYNC_BITS = 8, EOP_BITS = 8.
// Line captures are packed with bit k = tx_line in the k-th cycle after the first accept.
module tb_usb_hs_tx_serializer;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_last;
    logic       data_ready;
    logic       tx_en;
    logic       tx_line;
    logic       underrun;

    usb_hs_tx_serializer #(.SYNC_BITS(8), .EOP_BITS(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_ready (data_ready),
        .tx_en      (tx_en),
        .tx_line    (tx_line),
        .underrun   (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  pkt [4];
    int          pkt_n;
    bit          pkt_last;
    logic [63:0] cap_line, cap_en, cap_und, cap_rdy;
    int          en_cnt;
    int          n_acc;
    int          toggles;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx);
        if (idx < pkt_n) begin
            data_valid = 1'b1;
            data_in    = pkt[idx];
            data_last  = pkt_last && (idx == pkt_n - 1);
        end else begin
            data_valid = 1'b0;
            data_in    = 8'h00;
            data_last  = 1'b0;
        end
    endtask

    // Feeds pkt[] through valid/ready and records one sample per cycle until tx_en falls.
    task automatic run_pkt(input string tag);
        int  idx;
        bit  acc;
        bit  started;
        bit  done;
        idx = 0; started = 0; done = 0; en_cnt = 0;
        cap_line = '0; cap_en = '0; cap_und = '0; cap_rdy = '0;
        @(negedge clock);
        drive(idx);
        for (int k = 0; k < 60 && !done; k++) begin
            acc = data_valid && data_ready;
            @(posedge clock);
            #1;
            cap_line[k] = tx_line;
            cap_en[k]   = tx_en;
            cap_und[k]  = underrun;
            cap_rdy[k]  = data_ready;
            if (tx_en) begin
                en_cnt++;
                started = 1;
            end else if (started) begin
                done = 1;
            end
            if (acc) begin
                idx++;
                drive(idx);
            end
        end
        n_acc = idx;
        drive(pkt_n);
        check({tag, "_completes"}, 64'(done), 64'd1);
    endtask

    initial begin
        reset      = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        data_last  = 1'b0;
        pkt_n      = 0;
        pkt_last   = 0;
        #12;
        check("rst_tx_en",    64'(tx_en),      64'd0);
        check("rst_tx_line",  64'(tx_line),    64'd1);
        check("rst_underrun", 64'(underrun),   64'd0);
        check("rst_ready",    64'(data_ready), 64'd1);
        @(negedge clock);
        reset = 1'b1;

        // Reset in the middle of SYNC
        @(negedge clock);
        data_valid = 1'b1; data_in = 8'h00; data_last = 1'b1;
        @(posedge clock);
        #1;
        data_valid = 1'b0; data_last = 1'b0;
        check("midrst_started", 64'(tx_en), 64'd1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_tx_en",   64'(tx_en),   64'd0);
        check("midrst_tx_line", 64'(tx_line), 64'd1);
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("midrst_idle_en",    64'(tx_en),      64'd0);
        check("midrst_idle_ready", 64'(data_ready), 64'd1);

        // Single 0x00 with last
        pkt[0] = 8'h00; pkt_n = 1; pkt_last = 1;
        run_pkt("min");
        check("min_en_cycles", 64'(en_cnt), 64'd24);
        check("min_line",      64'(cap_line[23:0]), 64'h00552A);
        check("min_ready_busy", 64'(cap_rdy[0]), 64'd0);
        check("min_idle_line", 64'(cap_line[24]), 64'd1);
        check("min_idle_ready", 64'(cap_rdy[24]), 64'd1);

        // Single 0xFF with last: one stuff bit
        pkt[0] = 8'hFF; pkt_n = 1; pkt_last = 1;
        run_pkt("ff");
        check("ff_en_cycles", 64'(en_cnt), 64'd25);
        check("ff_line",      64'(cap_line[24:0]), 64'h1FFE02A);
        toggles = 0;
        for (int i = 8; i <= 16; i++) if (cap_line[i] != cap_line[i-1]) toggles++;
        check("ff_data_toggles", 64'(toggles), 64'd1);

        // Back-to-back stream
        pkt[0] = 8'hA5; pkt[1] = 8'h3C; pkt[2] = 8'h0F; pkt_n = 3; pkt_last = 1;
        run_pkt("b2b");
        check("b2b_accepted",  64'(n_acc), 64'd3);
        check("b2b_en_cycles", 64'(en_cnt), 64'd40);
        check("b2b_line",      64'(cap_line[39:0]), 64'h005041362A);
        check("b2b_ready_after_last", 64'(cap_rdy[39:17]), 64'd0);
        check("b2b_ready_idle", 64'(cap_rdy[40]), 64'd1);

        // Underrun after 0x12 without last
        pkt[0] = 8'h12; pkt_n = 1; pkt_last = 0;
        run_pkt("und");
        check("und_pulse",     cap_und, 64'h1 << 16);
        check("und_en_cycles", 64'(en_cnt), 64'd24);
        check("und_line",      64'(cap_line[23:0]), 64'h005B2A);
        check("und_idle_ready", 64'(cap_rdy[24]), 64'd1);

        // Stuff bit owed at packet end
        pkt[0] = 8'h00; pkt[1] = 8'hFC; pkt_n = 2; pkt_last = 1;
        run_pkt("tail");
        check("tail_en_cycles", 64'(en_cnt), 64'd33);
        check("tail_line",      64'(cap_line[32:0]), 64'h1FF01552A);
        check("tail_no_underrun", cap_und, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
